// File: rtl/sdiv_ctrl_if.sv
// Request/result handshake and unsigned-divider command/response bundle for sdiv_ctrl.
// Latency: none (wires only).
// Backpressure: o_ready/i_ready carry the valid-ready handshakes; the divider side has no backpressure.
interface sdiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_div_start;
  logic [WIDTH-1:0] o_div_a;
  logic [WIDTH-1:0] o_div_b;
  logic             i_div_done;
  logic             i_div_valid;
  logic             i_div_dbz;
  logic [WIDTH-1:0] i_div_val;
  logic [WIDTH-1:0] i_div_rem;

  // Controller side.
  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    input  i_div_done, i_div_valid, i_div_dbz, i_div_val, i_div_rem,
    output o_ready, o_valid, o_result, o_div_start, o_div_a, o_div_b
  );

  // Requester / divider side.
  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    output i_div_done, i_div_valid, i_div_dbz, i_div_val, i_div_rem,
    input  o_ready, o_valid, o_result, o_div_start, o_div_a, o_div_b
  );
endinterface

// File: rtl/sdiv_ctrl.sv
// Signed/unsigned DIV/REM front end around an external unsigned divider; optional result cache (SDIV_CACHE_EN).
// Latency: 1 cycle for divide-by-zero, signed overflow and cache hits; otherwise divider cycles + 2.
// Backpressure: one operation in flight; o_ready only in IDLE, result held in OUT until i_ready.
module sdiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic        i_clk,
  input logic        i_rst_n,
  sdiv_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t           state_q, state_d;
  logic             o_ready_q, o_ready_d;
  logic             o_valid_q, o_valid_d;
  logic             o_div_start_q, o_div_start_d;
  logic [WIDTH-1:0] o_result_q, o_result_d;
  logic [WIDTH-1:0] o_div_a_q, o_div_a_d;
  logic [WIDTH-1:0] o_div_b_q, o_div_b_d;
  logic             op_rem_q, op_rem_d;   // 1: remainder requested
  logic             sgn_q, sgn_d;         // 1: signed operation
  logic             aneg_q, aneg_d;       // dividend was negative (signed only)
  logic             bneg_q, bneg_d;       // divisor was negative (signed only)

  logic             req_sgn, a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] mag_a, mag_b, dvd, quo_fix, rem_fix;
  logic             cache_hit;
  logic [WIDTH-1:0] cache_res;

`ifdef SDIV_CACHE_EN
  logic             cache_vld_q, cache_vld_d;
  logic             cache_sgn_q, cache_sgn_d;
  logic [WIDTH-1:0] cache_a_q, cache_a_d;
  logic [WIDTH-1:0] cache_b_q, cache_b_d;
  logic [WIDTH-1:0] cache_quo_q, cache_quo_d;
  logic [WIDTH-1:0] cache_rem_q, cache_rem_d;

  assign cache_hit = cache_vld_q && (cache_a_q == bus.i_a) && (cache_b_q == bus.i_b)
                     && (cache_sgn_q == req_sgn);
  assign cache_res = bus.i_op[1] ? cache_rem_q : cache_quo_q;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // Request decode and result sign correction.
  always_comb begin
    req_sgn  = ~bus.i_op[0];
    a_neg    = req_sgn & bus.i_a[WIDTH-1];
    b_neg    = req_sgn & bus.i_b[WIDTH-1];
    mag_a    = a_neg ? -bus.i_a : bus.i_a;
    mag_b    = b_neg ? -bus.i_b : bus.i_b;
    div_zero = (bus.i_b == '0);
    ovf      = req_sgn && (bus.i_a == MIN_NEG) && (bus.i_b == ALL_ONES);
    // Original dividend rebuilt from magnitude and sign (MIN_NEG maps to itself).
    dvd      = aneg_q ? -o_div_a_q : o_div_a_q;
    quo_fix  = (sgn_q && (aneg_q ^ bneg_q)) ? -bus.i_div_val : bus.i_div_val;
    rem_fix  = aneg_q ? -bus.i_div_rem : bus.i_div_rem;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    o_ready_d     = o_ready_q;
    o_valid_d     = o_valid_q;
    o_div_start_d = o_div_start_q;
    o_result_d    = o_result_q;
    o_div_a_d     = o_div_a_q;
    o_div_b_d     = o_div_b_q;
    op_rem_d      = op_rem_q;
    sgn_d         = sgn_q;
    aneg_d        = aneg_q;
    bneg_d        = bneg_q;
`ifdef SDIV_CACHE_EN
    cache_vld_d   = cache_vld_q;
    cache_sgn_d   = cache_sgn_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid && o_ready_q) begin
          op_rem_d  = bus.i_op[1];
          sgn_d     = req_sgn;
          aneg_d    = a_neg;
          bneg_d    = b_neg;
          o_ready_d = 1'b0;
          if (div_zero || ovf || cache_hit) begin
            if (div_zero)  o_result_d = bus.i_op[1] ? bus.i_a : ALL_ONES;
            else if (ovf)  o_result_d = bus.i_op[1] ? '0 : bus.i_a;
            else           o_result_d = cache_res;
            o_valid_d = 1'b1;
            state_d   = S_OUT;
          end else begin
            o_div_a_d     = mag_a;
            o_div_b_d     = mag_b;
            o_div_start_d = 1'b1;
            state_d       = S_START;
          end
        end
      end
      S_START: begin
        o_div_start_d = 1'b0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_div_done && bus.i_div_valid) begin
          o_result_d = op_rem_q ? rem_fix : quo_fix;
          o_valid_d  = 1'b1;
          state_d    = S_OUT;
`ifdef SDIV_CACHE_EN
          cache_vld_d = 1'b1;
          cache_sgn_d = sgn_q;
          cache_a_d   = dvd;
          cache_b_d   = bneg_q ? -o_div_b_q : o_div_b_q;
          cache_quo_d = quo_fix;
          cache_rem_d = rem_fix;
`endif
        end else if (bus.i_div_done && bus.i_div_dbz) begin
          o_result_d = op_rem_q ? dvd : ALL_ONES;
          o_valid_d  = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.i_ready) begin
          o_valid_d = 1'b0;
          o_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and all registered outputs; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      o_ready_q     <= 1'b1;
      o_valid_q     <= 1'b0;
      o_div_start_q <= 1'b0;
      o_result_q    <= '0;
      o_div_a_q     <= '0;
      o_div_b_q     <= '0;
      op_rem_q      <= 1'b0;
      sgn_q         <= 1'b0;
      aneg_q        <= 1'b0;
      bneg_q        <= 1'b0;
`ifdef SDIV_CACHE_EN
      cache_vld_q   <= 1'b0;
      cache_sgn_q   <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      o_ready_q     <= o_ready_d;
      o_valid_q     <= o_valid_d;
      o_div_start_q <= o_div_start_d;
      o_result_q    <= o_result_d;
      o_div_a_q     <= o_div_a_d;
      o_div_b_q     <= o_div_b_d;
      op_rem_q      <= op_rem_d;
      sgn_q         <= sgn_d;
      aneg_q        <= aneg_d;
      bneg_q        <= bneg_d;
`ifdef SDIV_CACHE_EN
      cache_vld_q   <= cache_vld_d;
      cache_sgn_q   <= cache_sgn_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
`endif
    end
  end

  assign bus.o_ready     = o_ready_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_div_start = o_div_start_q;
  assign bus.o_result    = o_result_q;
  assign bus.o_div_a     = o_div_a_q;
  assign bus.o_div_b     = o_div_b_q;

endmodule

// File: tb/tb_sdiv_ctrl.sv
// Self-checking bench for sdiv_ctrl: directed vectors plus randomized operations against an arithmetic reference.
// Latency: checks 1-cycle special paths and divider-delay + 2 for divider paths.
// Backpressure: holds i_ready low for varying cycles and checks the result stays put.
module tb_sdiv_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  sdiv_ctrl_if #(.WIDTH(32)) bus ();

  sdiv_ctrl #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef SDIV_CACHE_EN
  bit          c_vld = 1'b0;
  bit          c_sgn;
  logic [31:0] c_a, c_b;
`endif

  // Reference: RISC-V style DIV/DIVU/REM/REMU from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // One complete operation: request, divider emulation with delay d, result check, release after hold cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int d, input int hold, input bit dbz_resp, input string nm);
    logic [31:0] exp_res, exp_da, exp_db, seen_res;
    bit          sgn, special, hit, exp_div, got;
    int          js, starts, lat, exp_lat;
    sgn     = !op[0];
    special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit     = 1'b0;
`ifdef SDIV_CACHE_EN
    hit = !special && c_vld && c_a == a && c_b == b && c_sgn == sgn;
`endif
    exp_div = !special && !hit;
    exp_res = ref_result(op, a, b);
    if (exp_div && dbz_resp) exp_res = op[1] ? a : 32'hFFFF_FFFF;
    exp_da  = (sgn && a[31]) ? -a : a;
    exp_db  = (sgn && b[31]) ? -b : b;
    exp_lat = exp_div ? d + 2 : 1;

    @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b want 1", nm, bus.o_ready);
    end
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
    js = 0; starts = 0; got = 1'b0; lat = 0;
    for (int j = 1; j <= 60 && !got; j++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_div_done = 1'b0; bus.i_div_valid = 1'b0; bus.i_div_dbz = 1'b0;
      if (bus.o_div_start === 1'b1) begin
        starts++; js = j;
        n_checks++;
        if (bus.o_div_a !== exp_da || bus.o_div_b !== exp_db) begin
          n_fail++; $display("FAIL %s div_operands: got %h/%h want %h/%h", nm, bus.o_div_a, bus.o_div_b, exp_da, exp_db);
        end
      end
      if (js != 0 && j == js + d) begin
        n_checks++;
        if (bus.o_div_a !== exp_da || bus.o_div_b !== exp_db) begin
          n_fail++; $display("FAIL %s div_operands_stable: got %h/%h want %h/%h", nm, bus.o_div_a, bus.o_div_b, exp_da, exp_db);
        end
        bus.i_div_done = 1'b1;
        bus.i_div_valid = !dbz_resp;
        bus.i_div_dbz = dbz_resp;
        bus.i_div_val = dbz_resp ? 32'd0 : exp_da / exp_db;
        bus.i_div_rem = dbz_resp ? 32'd0 : exp_da % exp_db;
      end
      if (bus.o_valid === 1'b1) begin got = 1'b1; lat = j; end
    end
    bus.i_div_done = 1'b0; bus.i_div_valid = 1'b0; bus.i_div_dbz = 1'b0;

    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL %s timeout: no o_valid within 60 cycles", nm);
    end
    n_checks++;
    if (bus.o_result !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h want %h", nm, bus.o_result, exp_res);
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
    end
    n_checks++;
    if (starts != (exp_div ? 1 : 0)) begin
      n_fail++; $display("FAIL %s div_start_count: got %0d want %0d", nm, starts, exp_div ? 1 : 0);
    end
    seen_res = bus.o_result;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== seen_res || bus.o_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s hold%0d: valid %b result %h ready %b want 1 %h 0",
                           nm, h, bus.o_valid, bus.o_result, bus.o_ready, seen_res);
      end
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: valid %b ready %b want 0 1", nm, bus.o_valid, bus.o_ready);
    end
`ifdef SDIV_CACHE_EN
    if (exp_div && !dbz_resp) begin
      c_vld = 1'b1; c_sgn = sgn; c_a = a; c_b = b;
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_div_start !== 1'b0 || bus.o_result !== 32'd0
        || bus.o_div_a !== 32'd0 || bus.o_div_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: valid %b start %b result %h a %h b %h want all 0",
                         bus.o_valid, bus.o_div_start, bus.o_result, bus.o_div_a, bus.o_div_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready %b valid %b want 1 0", bus.o_ready, bus.o_valid);
    end
`ifdef SDIV_CACHE_EN
    c_vld = 1'b0;
`endif
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 3, 0, 1'b0, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 2, 0, 1'b0, "rem_m7_2");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0, "divu_by0");
    run_op(2'b11, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0, "remu_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1'b0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1'b0, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 1'b0, "divu_no_ovf");
    run_op(2'b00, 32'd50, 32'hFFFF_FFF9, 4, 0, 1'b0, "div_pos_neg");
    run_op(2'b10, 32'hFFFF_FFCE, 32'hFFFF_FFF9, 1, 0, 1'b0, "rem_neg_neg");
  endtask

  task automatic test_backpressure();
    run_op(2'b01, 32'd1000, 32'd33, 2, 5, 1'b0, "hold_divider");
    run_op(2'b11, 32'd9, 32'd0, 1, 5, 1'b0, "hold_special");
  endtask

  task automatic test_divider_dbz();
    run_op(2'b00, 32'hFFFF_FFF0, 32'd3, 2, 0, 1'b0, "seed_cache");
    run_op(2'b10, 32'hFFFF_FFF0, 32'd5, 3, 0, 1'b1, "dbz_resp_rem");
    run_op(2'b01, 32'd77, 32'd5, 1, 1, 1'b1, "dbz_resp_divu");
  endtask

  task automatic test_spurious_done();
    @(negedge clk);
    bus.i_div_done = 1'b1; bus.i_div_valid = 1'b1; bus.i_div_dbz = 1'b1;
    bus.i_div_val = 32'h1234; bus.i_div_rem = 32'h5678;
    @(negedge clk);
    bus.i_div_done = 1'b0; bus.i_div_valid = 1'b0; bus.i_div_dbz = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_done_ignored: valid %b ready %b want 0 1", bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_op = 2'b00; bus.i_a = 32'd500; bus.i_b = 32'd7;
    @(negedge clk);
    bus.i_valid = 1'b0;
    seen = (bus.o_div_start === 1'b1);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL midrst_start: o_div_start %b want 1", bus.o_div_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SDIV_CACHE_EN
    c_vld = 1'b0;
`endif
    bus.i_div_done = 1'b1; bus.i_div_valid = 1'b1; bus.i_div_val = 32'd71; bus.i_div_rem = 32'd3;
    @(negedge clk);
    bus.i_div_done = 1'b0; bus.i_div_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_div_start !== 1'b0) begin
        n_fail++; $display("FAIL midrst_idle%0d: valid %b ready %b start %b want 0 1 0",
                           k, bus.o_valid, bus.o_ready, bus.o_div_start);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      if (kind == 0) b = 32'd0;
      else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind == 2) begin
        a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      run_op(op, a, b, $urandom_range(1, 5), $urandom_range(0, 2), 1'b0, $sformatf("rand%0d", i));
    end
  endtask

`ifdef SDIV_CACHE_EN
  task automatic test_cache();
    run_op(2'b00, 32'd100, 32'd7, 3, 0, 1'b0, "cache_fill");
    run_op(2'b10, 32'd100, 32'd7, 3, 0, 1'b0, "cache_hit_rem");
    run_op(2'b11, 32'd100, 32'd7, 2, 0, 1'b0, "cache_miss_remu");
    run_op(2'b01, 32'd100, 32'd0, 1, 0, 1'b0, "cache_by0");
    run_op(2'b01, 32'd100, 32'd7, 1, 0, 1'b0, "cache_hit_divu");
  endtask
`endif

  initial begin
    bus.i_valid = 1'b0; bus.i_op = 2'b00; bus.i_a = '0; bus.i_b = '0; bus.i_ready = 1'b0;
    bus.i_div_done = 1'b0; bus.i_div_valid = 1'b0; bus.i_div_dbz = 1'b0;
    bus.i_div_val = '0; bus.i_div_rem = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_divider_dbz();
    test_spurious_done();
    test_reset_mid_op();
`ifdef SDIV_CACHE_EN
    test_cache();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdiv_ctrl.md
SDIV_CTRL -- requirements
Module: sdiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (>=4, power of 2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  request accepted when i_valid&o_ready.
REQ-006 SHALL have port i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have ports i_a, i_b  input  WIDTH  dividend, divisor.
REQ-008 SHALL have port o_valid  output  1  result valid.
REQ-009 SHALL have port i_ready  input  1  consumer accepts result when o_valid&i_ready.
REQ-010 SHALL have port o_result  output  WIDTH  quotient or remainder per op.
REQ-011 SHALL have ports o_div_start  output  1, and o_div_a, o_div_b  output  WIDTH  unsigned divider command.
REQ-012 SHALL have ports i_div_done, i_div_valid, i_div_dbz  input  1, and i_div_val, i_div_rem  input  WIDTH  divider response.

Function
REQ-013 SHALL implement FSM IDLE, START, WAIT, OUT; o_ready=1 only in IDLE.
REQ-014 On accept in IDLE, SHALL register op, signedness, operand signs, and magnitudes (two's-complement abs when signed, raw when unsigned).
REQ-015 Divisor zero on accept SHALL go IDLE->OUT with result all-ones for DIV/DIVU, i_a for REM/REMU, without asserting o_div_start.
REQ-016 Signed overflow (i_a=100..0, i_b=all-ones, DIV/REM) SHALL go IDLE->OUT with result i_a for DIV, 0 for REM, without the divider.
REQ-017 Otherwise SHALL go IDLE->START; in START, o_div_start=1 for exactly one cycle with o_div_a/o_div_b = registered magnitudes, then ->WAIT.
REQ-018 o_div_a/o_div_b SHALL remain stable from START until leaving WAIT.
REQ-019 In WAIT on i_div_done&i_div_valid, SHALL capture i_div_val/i_div_rem and go ->OUT next cycle.
REQ-020 Signed quotient SHALL be negated when operand signs differ; signed remainder SHALL take the dividend's sign; unsigned results SHALL pass unchanged.
REQ-021 In WAIT on i_div_done&i_div_dbz, SHALL produce the REQ-015 results and go ->OUT.
REQ-022 In OUT, o_valid=1 and o_result SHALL hold stable until i_ready; on o_valid&i_ready ->IDLE (no same-cycle new accept).
REQ-023 i_div_done outside WAIT SHALL be ignored.
REQ-024 Latency accept->o_valid SHALL be 1 cycle for REQ-015/016, else (cycles from o_div_start to i_div_done)+2.

Reset
REQ-025 While i_rst_n=0, SHALL force state IDLE, o_ready=1 after deassert, o_valid=0, o_div_start=0, o_result=0, o_div_a=0, o_div_b=0, cache invalid.
REQ-026 Reset asserted mid-operation SHALL abort immediately; any later divider done SHALL be ignored per REQ-023.

Configuration
REQ-027 With SDIV_CACHE_EN defined, SHALL keep last divider-computed a, b, signedness, signed-corrected quotient and remainder, plus a valid bit.
REQ-028 With SDIV_CACHE_EN, an accepted request matching cached a, b and signedness SHALL go IDLE->OUT (1-cycle latency) returning cached quotient/remainder per op, without o_div_start.
REQ-029 Cache SHALL update only on REQ-019 completion; REQ-015/016 paths SHALL neither hit nor update it.
REQ-030 Without SDIV_CACHE_EN, no cache storage SHALL exist and every non-special request SHALL use the divider.

Verification
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> o_div_a=7, o_div_b=2; divider returns 3 rem 1 -> o_result=0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1).
REQ-032 DIVU a=0xFFFFFFFF, b=0 -> o_result=0xFFFFFFFF after 1 cycle, o_div_start never asserted; REMU -> 0xFFFFFFFF.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> o_result=0x80000000; REM -> 0; no o_div_start.
REQ-034 Result held with i_ready=0 for 5 cycles -> o_valid and o_result stable, o_ready=0; i_ready=1 -> o_ready=1 next cycle.
REQ-035 i_rst_n pulsed low during WAIT, then i_div_done arrives -> o_valid stays 0, FSM in IDLE, o_ready=1.
REQ-036 SDIV_CACHE_EN: DIV 100/7 then REM 100/7 -> second returns 2 one cycle after accept, no o_div_start; REMU 100/7 -> divider used.
